// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared RV64 definitions for the instruction encoder slice: the opcode
// constants that pick a non-I immediate format, the immediate format enum,
// and the opcode-to-format lookup that mirrors the datapath decoder.
//
// Optional feature macro: INSTRUCTION_ENCODER_UJ_EN
//   defined   -> LUI/AUIPC map to U format and JAL maps to J format.
//   undefined -> those opcodes fall back to I format, matching the current decoder.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 64;

  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_t;

  // Every opcode not explicitly listed is treated as I format, so the
  // decoder and encoder agree even on opcodes neither really supports.
  function automatic imm_fmt_t opcode_fmt(input logic [6:0] opcode);
    imm_fmt_t fmt;
    case (opcode)
      OPC_STORE:  fmt = FMT_S;
      OPC_BRANCH: fmt = FMT_B;
`ifdef INSTRUCTION_ENCODER_UJ_EN
      OPC_LUI,
      OPC_AUIPC:  fmt = FMT_U;
      OPC_JAL:    fmt = FMT_J;
`endif
      default:    fmt = FMT_I;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// instruction_encoder_if
// Request/response bundle of the instruction encoder.
//   request : in_valid/in_ready handshake plus opcode, rd, funct3, rs1, rs2, imm
//   response: out_valid/out_ready handshake plus encoded word and its address
//   errors  : err_pulse (one cycle per rejected input), err_count (saturating)
// Modports:
//   master - the producer of requests / consumer of encoded words
//   slave  - the encoder itself
interface instruction_encoder_if #(
  parameter int XLEN      = riscv_pkg::XLEN_DEFAULT,
  parameter int ERR_CNT_W = 8
);

  logic                 in_valid;
  logic                 in_ready;
  logic [6:0]           in_opcode;
  logic [4:0]           in_rd;
  logic [2:0]           in_funct3;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [XLEN-1:0]      in_imm;

  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic [XLEN-1:0]      out_addr;

  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_imm,
    output out_ready,
    input  in_ready,
    input  out_valid, out_instr, out_addr,
    input  err_pulse, err_count
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_imm,
    input  out_ready,
    output in_ready,
    output out_valid, out_instr, out_addr,
    output err_pulse, err_count
  );

endinterface

// File: rtl/instruction_encoder_imm_packer.sv
// imm_packer
// Purely combinational packing of opcode, register fields and a sign-extended
// immediate into a 32-bit instruction word, plus a legality flag that says
// whether the immediate is representable in the selected format.
// Ports:
//   opcode, rd, funct3, rs1, rs2, imm : instruction fields
//   instr                             : packed 32-bit word
//   legal                             : immediate fits the format
// Optional feature macro: INSTRUCTION_ENCODER_UJ_EN (U/J formats, see riscv_pkg).
module imm_packer
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [6:0]      opcode,
  input  logic [4:0]      rd,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [XLEN-1:0] imm,
  output logic [31:0]     instr,
  output logic            legal
);

  imm_fmt_t fmt;

  // True when value[XLEN-1:lsb] are all copies of the same bit, i.e. the
  // immediate survives truncation to a signed field whose sign bit is lsb.
  function automatic logic fits_signed(input logic [XLEN-1:0] value, input int unsigned lsb);
    logic signed [XLEN-1:0] shifted;
    shifted = $signed(value) >>> lsb;
    return (shifted == '0) || (&shifted);
  endfunction

  assign fmt = opcode_fmt(opcode);

  // Bit placement is the exact inverse of the datapath immediate decoder.
  // B and J immediates are halfword offsets, so bit 0 must be clear.
  always_comb begin
    instr = '0;
    legal = 1'b0;
    case (fmt)
      FMT_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        legal = fits_signed(imm, 11);
      end
      FMT_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        legal = fits_signed(imm, 12) && !imm[0];
      end
      FMT_U: begin
        instr = {imm[31:12], rd, opcode};
        legal = fits_signed(imm, 31) && (imm[11:0] == 12'd0);
      end
      FMT_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        legal = fits_signed(imm, 20) && !imm[0];
      end
      default: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        legal = fits_signed(imm, 11);
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder
// Streaming RV64 instruction encoder used by the program loader: accepts one
// field bundle per handshake, emits the encoded word one cycle later together
// with a sequential address, and rejects (and counts) immediates that do not
// fit the selected format.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   clear : synchronous flush, drops any pending word and restarts addressing
//   bus   : instruction_encoder_if.slave (request, response and error signals)
// Parameters:
//   XLEN      : immediate and address width
//   BASE_ADDR : address of the first word after reset/clear (multiple of 4)
//   ERR_CNT_W : width of the saturating reject counter
// Optional feature macro: INSTRUCTION_ENCODER_UJ_EN (U/J formats, see riscv_pkg).
module instruction_encoder
  import riscv_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  parameter int              ERR_CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  clear,
  instruction_encoder_if.slave bus
);

  localparam logic [XLEN-1:0] ADDR_STEP = XLEN'(4);

  logic                 out_valid_q;
  logic [31:0]          out_instr_q;
  logic [XLEN-1:0]      out_addr_q;
  logic [XLEN-1:0]      next_addr_q;
  logic                 err_pulse_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  logic [31:0]          packed_instr;
  logic                 packed_legal;
  logic                 accept;

  imm_packer #(
    .XLEN (XLEN)
  ) u_packer (
    .opcode (bus.in_opcode),
    .rd     (bus.in_rd),
    .funct3 (bus.in_funct3),
    .rs1    (bus.in_rs1),
    .rs2    (bus.in_rs2),
    .imm    (bus.in_imm),
    .instr  (packed_instr),
    .legal  (packed_legal)
  );

  // The single output register is free when empty or being drained this
  // cycle; clear blocks acceptance so a flushed cycle never leaks a word.
  assign bus.in_ready = !clear && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Output register and address counter. A legal accept loads the word at
  // the current next-address; an illegal accept completes the handshake but
  // loads nothing, so out_valid falls if the held word is drained meanwhile.
  // Instr/addr keep their last values once the word has been consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      next_addr_q <= BASE_ADDR;
    end else if (clear) begin
      out_valid_q <= 1'b0;
      next_addr_q <= BASE_ADDR;
    end else if (accept && packed_legal) begin
      out_valid_q <= 1'b1;
      out_instr_q <= packed_instr;
      out_addr_q  <= next_addr_q;
      next_addr_q <= next_addr_q + ADDR_STEP;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Reject reporting: a one-cycle pulse per rejected input and a counter
  // that sticks at all-ones rather than wrapping back to a small value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else if (clear) begin
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= accept && !packed_legal;
      if (accept && !packed_legal && (err_count_q != {ERR_CNT_W{1'b1}})) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder
// Self-checking bench for instruction_encoder. Two instances: one at
// BASE_ADDR 0 for the functional scenarios and one at BASE_ADDR
// 64'hFFFF_FFFF_FFFF_FFF8 for address wrap and clear. Expected words are
// pushed to a scoreboard queue when driven and popped when the DUT shows them.
// Honours INSTRUCTION_ENCODER_UJ_EN for the JAL scenario.
module tb_instruction_encoder;
  import riscv_pkg::*;

  localparam int              XLEN      = 64;
  localparam int              ERR_CNT_W = 8;
  localparam logic [XLEN-1:0] WRAP_BASE = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [6:0]      OP_IMM    = 7'b0010011;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] addr;
  } sb_entry_t;

  logic clk;
  logic rst_n;
  logic clear;
  logic wclear;

  sb_entry_t       sb[$];
  sb_entry_t       wsb[$];
  logic [XLEN-1:0] exp_addr;
  logic [XLEN-1:0] wexp_addr;
  int              exp_errs;
  int              checks;
  int              passed;

  instruction_encoder_if #(.XLEN(XLEN), .ERR_CNT_W(ERR_CNT_W)) bus ();
  instruction_encoder_if #(.XLEN(XLEN), .ERR_CNT_W(ERR_CNT_W)) wbus ();

  instruction_encoder #(
    .XLEN      (XLEN),
    .BASE_ADDR ('0),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  instruction_encoder #(
    .XLEN      (XLEN),
    .BASE_ADDR (WRAP_BASE),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (wclear),
    .bus   (wbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a scenario stalls unexpectedly.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive_in(input logic v, input logic [6:0] opc, input logic [4:0] rd,
                          input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [XLEN-1:0] imm);
    bus.in_valid  = v;
    bus.in_opcode = opc;
    bus.in_rd     = rd;
    bus.in_funct3 = f3;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
  endtask

  task automatic wdrive_in(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] imm);
    wbus.in_valid  = v;
    wbus.in_opcode = OP_IMM;
    wbus.in_rd     = rd;
    wbus.in_funct3 = 3'd0;
    wbus.in_rs1    = 5'd0;
    wbus.in_rs2    = 5'd0;
    wbus.in_imm    = imm;
  endtask

  task automatic test_reset();
    rst_n  = 1'b1;
    clear  = 1'b0;
    wclear = 1'b0;
    bus.out_ready  = 1'b1;
    wbus.out_ready = 1'b1;
    drive_in(1'b0, OP_IMM, 5'd0, 3'd0, 5'd0, 5'd0, '0);
    wdrive_in(1'b0, 5'd0, '0);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.out_instr !== 32'd0) $display("[TB] FAIL reset_out_instr: got %h want 0", bus.out_instr); else passed++;
    checks++; if (bus.out_addr !== 64'd0) $display("[TB] FAIL reset_out_addr: got %h want 0", bus.out_addr); else passed++;
    checks++; if (bus.err_pulse !== 1'b0) $display("[TB] FAIL reset_err_pulse: got %b want 0", bus.err_pulse); else passed++;
    checks++; if (bus.err_count !== 8'd0) $display("[TB] FAIL reset_err_count: got %0d want 0", bus.err_count); else passed++;
    checks++; if (wbus.out_valid !== 1'b0) $display("[TB] FAIL reset_wrap_valid: got %b want 0", wbus.out_valid); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); else passed++;
    exp_addr  = '0;
    wexp_addr = WRAP_BASE;
    exp_errs  = 0;
  endtask

  task automatic test_basic();
    sb_entry_t e;
    drive_in(1'b1, OP_IMM, 5'd1, 3'd0, 5'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    sb.push_back('{instr: 32'hFFF10093, addr: exp_addr});
    exp_addr += 4;
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL basic_in_ready: got %b want 1", bus.in_ready); else passed++;
    @(negedge clk);
    drive_in(1'b0, OP_IMM, 5'd0, 3'd0, 5'd0, 5'd0, '0);
    checks++;
    if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
      $display("[TB] FAIL basic_valid: got out_valid=%b queued=%0d want 1 with a queued word", bus.out_valid, sb.size());
    end else begin
      passed++;
      e = sb.pop_front();
      checks++; if (bus.out_instr !== e.instr) $display("[TB] FAIL basic_instr: got %h want %h", bus.out_instr, e.instr); else passed++;
      checks++; if (bus.out_addr !== e.addr) $display("[TB] FAIL basic_addr: got %h want %h", bus.out_addr, e.addr); else passed++;
    end
  endtask

  task automatic test_s_b();
    sb_entry_t e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
          $display("[TB] FAIL sb_valid[%0d]: got out_valid=%b queued=%0d want 1 with a queued word", i, bus.out_valid, sb.size());
        end else begin
          passed++;
          e = sb.pop_front();
          checks++; if (bus.out_instr !== e.instr) $display("[TB] FAIL sb_instr[%0d]: got %h want %h", i, bus.out_instr, e.instr); else passed++;
          checks++; if (bus.out_addr !== e.addr) $display("[TB] FAIL sb_addr[%0d]: got %h want %h", i, bus.out_addr, e.addr); else passed++;
        end
      end
      if (i == 0) begin
        drive_in(1'b1, OPC_STORE, 5'd0, 3'd3, 5'd2, 5'd3, 64'd8);
        sb.push_back('{instr: 32'h00313423, addr: exp_addr});
        exp_addr += 4;
      end else if (i == 1) begin
        drive_in(1'b1, OPC_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFC);
        sb.push_back('{instr: 32'hFE208EE3, addr: exp_addr});
        exp_addr += 4;
      end else begin
        drive_in(1'b0, OP_IMM, 5'd0, 3'd0, 5'd0, 5'd0, '0);
      end
    end
  endtask

  task automatic test_hold();
    sb_entry_t e;
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive_in(1'b1, OP_IMM, 5'd5, 3'd0, 5'd0, 5'd0, 64'd1);
    sb.push_back('{instr: 32'h00100293, addr: exp_addr});
    exp_addr += 4;
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_in(1'b1, OP_IMM, 5'd6, 3'd0, 5'd0, 5'd0, 64'd2);
    sb.push_back('{instr: 32'h00200313, addr: exp_addr});
    exp_addr += 4;
    #1;
    checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL hold_in_ready_first: got %b want 0", bus.in_ready); else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL hold_in_ready[%0d]: got %b want 0", k, bus.in_ready); else passed++;
      checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL hold_valid[%0d]: got %b want 1", k, bus.out_valid); else passed++;
      checks++; if (bus.out_instr !== sb[0].instr) $display("[TB] FAIL hold_instr[%0d]: got %h want %h", k, bus.out_instr, sb[0].instr); else passed++;
      checks++; if (bus.out_addr !== sb[0].addr) $display("[TB] FAIL hold_addr[%0d]: got %h want %h", k, bus.out_addr, sb[0].addr); else passed++;
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL hold_release_ready: got %b want 1", bus.in_ready); else passed++;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
        $display("[TB] FAIL hold_drain_valid[%0d]: got out_valid=%b queued=%0d want 1 with a queued word", i, bus.out_valid, sb.size());
      end else begin
        passed++;
        e = sb.pop_front();
        checks++; if (bus.out_instr !== e.instr) $display("[TB] FAIL hold_drain_instr[%0d]: got %h want %h", i, bus.out_instr, e.instr); else passed++;
        checks++; if (bus.out_addr !== e.addr) $display("[TB] FAIL hold_drain_addr[%0d]: got %h want %h", i, bus.out_addr, e.addr); else passed++;
      end
      if (i == 1) begin
        drive_in(1'b1, OP_IMM, 5'd7, 3'd0, 5'd0, 5'd0, 64'd3);
        sb.push_back('{instr: 32'h00300393, addr: exp_addr});
        exp_addr += 4;
      end else if (i == 2) begin
        drive_in(1'b0, OP_IMM, 5'd0, 3'd0, 5'd0, 5'd0, '0);
      end
    end
  endtask

  task automatic test_reject();
    sb_entry_t e;
    sb_entry_t last;
    last = '0;
    @(negedge clk);
    drive_in(1'b1, OP_IMM, 5'd3, 3'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_F800);
    sb.push_back('{instr: 32'h80000193, addr: exp_addr});
    exp_addr += 4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0 || i == 3) begin
        checks++;
        if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
          $display("[TB] FAIL rej_valid[%0d]: got out_valid=%b queued=%0d want 1 with a queued word", i, bus.out_valid, sb.size());
        end else begin
          passed++;
          e = sb.pop_front();
          last = e;
          checks++; if (bus.out_instr !== e.instr) $display("[TB] FAIL rej_instr[%0d]: got %h want %h", i, bus.out_instr, e.instr); else passed++;
          checks++; if (bus.out_addr !== e.addr) $display("[TB] FAIL rej_addr[%0d]: got %h want %h", i, bus.out_addr, e.addr); else passed++;
        end
      end
      if (i == 1 || i == 2) begin
        exp_errs++;
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL rej_no_word[%0d]: got %b want 0", i, bus.out_valid); else passed++;
        checks++; if (bus.err_pulse !== 1'b1) $display("[TB] FAIL rej_pulse[%0d]: got %b want 1", i, bus.err_pulse); else passed++;
        checks++; if (bus.err_count !== 8'(exp_errs)) $display("[TB] FAIL rej_count[%0d]: got %0d want %0d", i, bus.err_count, exp_errs); else passed++;
      end
      if (i == 3) begin
        checks++; if (bus.err_pulse !== 1'b0) $display("[TB] FAIL rej_pulse_drop: got %b want 0", bus.err_pulse); else passed++;
      end
      if (i == 4) begin
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL rej_idle_valid: got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.out_instr !== last.instr) $display("[TB] FAIL rej_keep_instr: got %h want %h", bus.out_instr, last.instr); else passed++;
        checks++; if (bus.out_addr !== last.addr) $display("[TB] FAIL rej_keep_addr: got %h want %h", bus.out_addr, last.addr); else passed++;
      end
      if (i == 0) begin
        drive_in(1'b1, OP_IMM, 5'd0, 3'd0, 5'd0, 5'd0, 64'd2048);
      end else if (i == 1) begin
        drive_in(1'b1, OPC_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 64'd5);
      end else if (i == 2) begin
        drive_in(1'b1, OP_IMM, 5'd4, 3'd0, 5'd0, 5'd0, 64'd2047);
        sb.push_back('{instr: 32'h7FF00213, addr: exp_addr});
        exp_addr += 4;
      end else begin
        drive_in(1'b0, OP_IMM, 5'd0, 3'd0, 5'd0, 5'd0, '0);
      end
    end
  endtask

  task automatic test_jal();
    sb_entry_t e;
    @(negedge clk);
    drive_in(1'b1, 7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 64'd2048);
`ifdef INSTRUCTION_ENCODER_UJ_EN
    sb.push_back('{instr: 32'h001000EF, addr: exp_addr});
    exp_addr += 4;
    @(negedge clk);
    drive_in(1'b0, OP_IMM, 5'd0, 3'd0, 5'd0, 5'd0, '0);
    checks++;
    if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
      $display("[TB] FAIL jal_valid: got out_valid=%b queued=%0d want 1 with a queued word", bus.out_valid, sb.size());
    end else begin
      passed++;
      e = sb.pop_front();
      checks++; if (bus.out_instr !== e.instr) $display("[TB] FAIL jal_instr: got %h want %h", bus.out_instr, e.instr); else passed++;
      checks++; if (bus.out_addr !== e.addr) $display("[TB] FAIL jal_addr: got %h want %h", bus.out_addr, e.addr); else passed++;
    end
`else
    e = '0;
    exp_errs++;
    @(negedge clk);
    drive_in(1'b0, OP_IMM, 5'd0, 3'd0, 5'd0, 5'd0, '0);
    checks++; if (bus.out_valid !== e.instr[0]) $display("[TB] FAIL jal_as_i_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.err_pulse !== 1'b1) $display("[TB] FAIL jal_as_i_pulse: got %b want 1", bus.err_pulse); else passed++;
    checks++; if (bus.err_count !== 8'(exp_errs)) $display("[TB] FAIL jal_as_i_count: got %0d want %0d", bus.err_count, exp_errs); else passed++;
`endif
  endtask

  task automatic test_clear();
    sb_entry_t e;
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_in(1'b1, OP_IMM, 5'd8, 3'd0, 5'd0, 5'd0, 64'd4);
    sb.push_back('{instr: 32'h00400413, addr: exp_addr});
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL clr_pending: got %b want 1", bus.out_valid); else passed++;
    clear = 1'b1;
    drive_in(1'b1, OP_IMM, 5'd9, 3'd0, 5'd0, 5'd0, 64'd5);
    #1;
    checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL clr_in_ready: got %b want 0", bus.in_ready); else passed++;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL clr_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.err_count !== 8'd0) $display("[TB] FAIL clr_err_count: got %0d want 0", bus.err_count); else passed++;
    checks++; if (bus.err_pulse !== 1'b0) $display("[TB] FAIL clr_err_pulse: got %b want 0", bus.err_pulse); else passed++;
    sb.delete();
    exp_addr = '0;
    exp_errs = 0;
    bus.out_ready = 1'b1;
    drive_in(1'b1, OP_IMM, 5'd10, 3'd0, 5'd0, 5'd0, 64'd6);
    sb.push_back('{instr: 32'h00600513, addr: exp_addr});
    exp_addr += 4;
    @(negedge clk);
    drive_in(1'b0, OP_IMM, 5'd0, 3'd0, 5'd0, 5'd0, '0);
    checks++;
    if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
      $display("[TB] FAIL clr_next_valid: got out_valid=%b queued=%0d want 1 with a queued word", bus.out_valid, sb.size());
    end else begin
      passed++;
      e = sb.pop_front();
      checks++; if (bus.out_instr !== e.instr) $display("[TB] FAIL clr_next_instr: got %h want %h", bus.out_instr, e.instr); else passed++;
      checks++; if (bus.out_addr !== e.addr) $display("[TB] FAIL clr_next_addr: got %h want %h", bus.out_addr, e.addr); else passed++;
    end
  endtask

  task automatic test_wrap();
    sb_entry_t e;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1 || i == 2 || i == 3 || i == 7) begin
        checks++;
        if (wbus.out_valid !== 1'b1 || wsb.size() == 0) begin
          $display("[TB] FAIL wrap_valid[%0d]: got out_valid=%b queued=%0d want 1 with a queued word", i, wbus.out_valid, wsb.size());
        end else begin
          passed++;
          e = wsb.pop_front();
          checks++; if (wbus.out_instr !== e.instr) $display("[TB] FAIL wrap_instr[%0d]: got %h want %h", i, wbus.out_instr, e.instr); else passed++;
          checks++; if (wbus.out_addr !== e.addr) $display("[TB] FAIL wrap_addr[%0d]: got %h want %h", i, wbus.out_addr, e.addr); else passed++;
        end
      end
      if (i == 4) begin
        checks++; if (wbus.out_valid !== 1'b0) $display("[TB] FAIL wrap_rej_valid: got %b want 0", wbus.out_valid); else passed++;
        checks++; if (wbus.err_count !== 8'd1) $display("[TB] FAIL wrap_rej_count: got %0d want 1", wbus.err_count); else passed++;
      end
      if (i == 5) begin
        checks++; if (wbus.out_valid !== 1'b1) $display("[TB] FAIL wrap_pending: got %b want 1", wbus.out_valid); else passed++;
      end
      if (i == 6) begin
        checks++; if (wbus.out_valid !== 1'b0) $display("[TB] FAIL wrap_clr_valid: got %b want 0", wbus.out_valid); else passed++;
        checks++; if (wbus.err_count !== 8'd0) $display("[TB] FAIL wrap_clr_count: got %0d want 0", wbus.err_count); else passed++;
        wsb.delete();
        wexp_addr = WRAP_BASE;
      end
      if (i < 3 || i == 4 || i == 6) begin
        wclear = 1'b0;
        wbus.out_ready = 1'b1;
        wdrive_in(1'b1, 5'(i + 1), '0);
        wsb.push_back('{instr: {20'd0, 5'(i + 1), OP_IMM}, addr: wexp_addr});
        wexp_addr += 4;
      end else if (i == 3) begin
        wdrive_in(1'b1, 5'd0, 64'd4096);
      end else if (i == 5) begin
        wclear = 1'b1;
        wbus.out_ready = 1'b0;
        wdrive_in(1'b1, 5'd9, '0);
        #1;
        checks++; if (wbus.in_ready !== 1'b0) $display("[TB] FAIL wrap_clr_ready: got %b want 0", wbus.in_ready); else passed++;
      end else begin
        wdrive_in(1'b0, 5'd0, '0);
      end
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    $display("[TB] instruction_encoder bench start");
    test_reset();
    test_basic();
    test_s_b();
    test_hold();
    test_reject();
    test_jal();
    test_clear();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
